// File: rtl/aes64_decrypt_iter.sv
// Iterative decryptor for the 64-bit, ROUNDS-round AES-style cipher.
// It applies one inverse round per clock on a single state register and keeps one block in flight.
module aes64_decrypt_iter #(
  parameter int unsigned ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy
);
  // Handshake: a transfer occurs on a rising edge where valid and ready are both high.
  // valid never depends on ready, and out_valid/plaintext hold until the transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);

  state_e      state_q, state_d;
  logic [63:0] blk_q, blk_d;
  logic [63:0] key_q, key_d;
  logic [63:0] pt_q, pt_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] u;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [63:0] inv_shift_rows(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    r[55:48] = s[23:16];
    r[23:16] = s[55:48];
    r[39:32] = s[7:0];
    r[7:0]   = s[39:32];
    return r;
  endfunction

  function automatic logic [63:0] inv_sub_bytes(input logic [63:0] s);
    logic [63:0] r, t;
    r = '0;
    t = s;
    for (int i = 0; i < 8; i++) begin
      r = {r[55:0], inv_sbox(t[63:56])};
      t = t << 8;
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
            gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
            gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
            gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    key_d   = key_q;
    pt_d    = pt_q;
    rnd_d   = rnd_q;
    u       = inv_sub_bytes(inv_shift_rows(blk_q)) ^ key_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = ciphertext ^ key;
          key_d   = key;
          rnd_d   = ROUNDS_L;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // The final round skips InvMixColumns and lands straight in the output register.
        if (rnd_q == 4'd1) begin
          pt_d    = u;
          state_d = DONE;
        end else begin
          blk_d = {inv_mix_col(u[63:32]), inv_mix_col(u[31:0])};
          rnd_d = rnd_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes64_decrypt_iter.sv
// Directed and round-trip bench for aes64_decrypt_iter, with a golden encrypt model.
`timescale 1ns/1ps
module tb_aes64_decrypt_iter;
  localparam int unsigned ROUNDS = 8;
  localparam int          NB2B   = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] ciphertext, key, plaintext;
  logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready, r1_busy;
  logic [63:0] r1_ct, r1_key, r1_pt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  sbox_tab [256];
  logic [63:0] exp_q[$];
  logic [63:0] p_v, k_v, p2_v, k2_v, pending_p;
  int          n_in, n_out, cyc, last_acc, wait_n;
  logic        acc;

  always #5 clk = ~clk;

  aes64_decrypt_iter #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .plaintext(plaintext), .busy(busy)
  );

  aes64_decrypt_iter #(.ROUNDS(1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(r1_in_valid), .in_ready(r1_in_ready),
    .ciphertext(r1_ct), .key(r1_key), .out_valid(r1_out_valid), .out_ready(r1_out_ready),
    .plaintext(r1_pt), .busy(r1_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Golden encrypt model: forward S-box from a brute-force field inverse and the forward affine map.
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[v] = inv ^ {inv[3:0], inv[7:4]} ^ {inv[4:0], inv[7:5]} ^
                    {inv[5:0], inv[7:6]} ^ {inv[6:0], inv[7]} ^ 8'h63;
    end
  endtask

  function automatic logic [63:0] sub_bytes(input logic [63:0] s);
    logic [63:0] r, t;
    r = '0;
    t = s;
    for (int i = 0; i < 8; i++) begin
      r = {r[55:0], sbox_tab[t[63:56]]};
      t = t << 8;
    end
    return r;
  endfunction

  function automatic logic [63:0] shift_rows(input logic [63:0] s);
    return {s[63:56], s[23:16], s[47:40], s[7:0], s[31:24], s[55:48], s[15:8], s[39:32]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {tb_mul(8'h02, a0) ^ tb_mul(8'h03, a1) ^ a2 ^ a3,
            a0 ^ tb_mul(8'h02, a1) ^ tb_mul(8'h03, a2) ^ a3,
            a0 ^ a1 ^ tb_mul(8'h02, a2) ^ tb_mul(8'h03, a3),
            tb_mul(8'h03, a0) ^ a1 ^ a2 ^ tb_mul(8'h02, a3)};
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] p, input logic [63:0] k, input int rounds);
    logic [63:0] s;
    s = shift_rows(sub_bytes(p ^ k));
    for (int r = 1; r < rounds; r++)
      s = shift_rows(sub_bytes({mix_col(s[63:32]), mix_col(s[31:0])} ^ k));
    return s ^ k;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send(input logic [63:0] ct, input logic [63:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", in_ready, 1);
    in_valid   = 1'b1;
    ciphertext = ct;
    key        = k;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ciphertext = rnd64();
    key        = rnd64();
  endtask

  task automatic recv(input string tag, input logic [63:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check(tag, plaintext, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic r1_run(input string tag, input logic [63:0] ct, input logic [63:0] k,
                        input logic [63:0] exp);
    @(negedge clk);
    check({tag, "_in_ready"}, r1_in_ready, 1);
    r1_in_valid = 1'b1;
    r1_ct       = ct;
    r1_key      = k;
    @(posedge clk);
    #1;
    r1_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid_A"}, r1_out_valid, 0);
    @(negedge clk);
    check({tag, "_valid_A1"}, r1_out_valid, 1);
    check(tag, r1_pt, exp);
    r1_out_ready = 1'b1;
    @(posedge clk);
    #1;
    r1_out_ready = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0; key = '0;
    r1_in_valid = 1'b0; r1_out_ready = 1'b0; r1_ct = '0; r1_key = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_plaintext", plaintext, 64'h0);
    rst_n = 1'b1;

    // ROUNDS=1 hand-computed vectors and a few random round trips
    r1_run("r1_zero", 64'h6363636363636363, 64'h0, 64'h0);
    r1_run("r1_ones", 64'h9C9C9C9C9C9C9C9C, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      p_v = rnd64();
      k_v = rnd64();
      r1_run("r1_rand", enc(p_v, k_v, 1), k_v, p_v);
    end

    // Directed 8-round vector with latency and busy timing
    p_v = 64'h0123456789ABCDEF;
    k_v = 64'h0F1E2D3C4B5A6978;
    send(enc(p_v, k_v, ROUNDS), k_v);
    for (int k = 0; k < int'(ROUNDS); k++) begin
      @(negedge clk);
      check("lat_out_valid_low", out_valid, 0);
      check("lat_busy", busy, 1);
      check("lat_in_ready_low", in_ready, 0);
    end
    @(negedge clk);
    check("lat_out_valid_high", out_valid, 1);
    check("lat_busy_done", busy, 1);
    check("directed_pt", plaintext, p_v);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("after_hs_out_valid", out_valid, 0);
    check("after_hs_busy", busy, 0);
    check("after_hs_in_ready", in_ready, 1);
    check("after_hs_pt_kept", plaintext, p_v);

    for (int i = 0; i < 1000; i++) begin
      p_v = rnd64();
      k_v = rnd64();
      send(enc(p_v, k_v, ROUNDS), k_v);
      recv("rand_roundtrip", p_v);
    end

    // Backpressure with stray input pulses during ROUND and DONE
    p_v  = 64'hDEADBEEFCAFEF00D;
    k_v  = 64'h1122334455667788;
    p2_v = 64'h0BADF00D12345678;
    k2_v = 64'h8877665544332211;
    send(enc(p_v, k_v, ROUNDS), k_v);
    wait_n = 0;
    while (!out_valid && wait_n < 40) begin
      @(negedge clk);
      in_valid = 1'b1; ciphertext = rnd64(); key = rnd64();
      wait_n++;
    end
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_pt_stable", plaintext, p_v);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
      in_valid = 1'b1; ciphertext = rnd64(); key = rnd64();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_final_pt", plaintext, p_v);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(enc(p2_v, k2_v, ROUNDS), k2_v);
    recv("bp_next_block", p2_v);

    // Reset in the middle of a block
    send(enc(p_v ^ 64'h1, k_v, ROUNDS), k_v);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_plaintext", plaintext, 64'h0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(enc(p2_v ^ 64'h5, k2_v, ROUNDS), k2_v);
    recv("rst_fresh_block", p2_v ^ 64'h5);

    // Back-to-back with in_valid and out_ready held high
    n_in = 0; n_out = 0; cyc = 0; last_acc = -1;
    out_ready  = 1'b1;
    pending_p  = rnd64();
    k_v        = rnd64();
    ciphertext = enc(pending_p, k_v, ROUNDS);
    key        = k_v;
    in_valid   = 1'b1;
    while (n_out < NB2B && cyc < 200) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      if (acc) begin
        exp_q.push_back(pending_p);
        if (last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'(ROUNDS + 2));
        last_acc = cyc;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("b2b_extra_output", 1, 0);
        else check("b2b_data", plaintext, exp_q.pop_front());
        n_out++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        n_in++;
        if (n_in < NB2B) begin
          pending_p  = rnd64();
          k_v        = rnd64();
          ciphertext = enc(pending_p, k_v, ROUNDS);
          key        = k_v;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_outputs", 64'(n_out), 64'(NB2B));
    check("b2b_inputs", 64'(n_in), 64'(NB2B));
    check("b2b_queue_empty", 64'(exp_q.size()), 64'h0);
    repeat (ROUNDS + 3) begin
      @(negedge clk);
      check("b2b_no_dup", out_valid, 0);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
